comm_ahb_slave: RTL and testbench

- AHB-Lite responder (slave) for the COMM controller's AHB-Lite master port: a word-organised register memory with programmable wait states and a two-cycle ERROR response.
- Serves as the on-chip scratch target and as the bench target for COMM bus transactions (write, read, read-out, bus error).
- Sits on the AHB-Lite bus next to the CM0; selected by hsel from the bus decoder.

---
 rtl/comm_ahb_slave.sv | 156 +++++++++++++++
 tb/tb_comm_ahb_slave.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/comm_ahb_slave.sv
// AHB-Lite responder: word-organised register memory with programmable wait states,
// two-cycle ERROR response for out-of-window, oversize or misaligned transfers.
module comm_ahb_slave #(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE        = 32'h2000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [7:0]  err_cnt
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN    = 32'(4 * DEPTH);
  localparam logic [3:0]  WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  logic [31:0]   r_mem [DEPTH];
  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lane;
  logic          r_write;
  logic [2:0]    r_size;
  logic [3:0]    r_wcnt;
  logic [31:0]   r_hrdata;
  logic          r_hreadyout;
  logic          r_hresp;
  logic [7:0]    r_err_cnt;

  logic          w_accept;
  logic [31:0]   w_off;
  logic          w_in_range;
  logic          w_misalign;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_rd_idx;
  logic [3:0]    w_cur_be;
  logic          w_fwd;
  logic [31:0]   w_rd_word;

  function automatic logic [3:0] byteEn(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      3'd0:    return 4'b0001 << lane;
      3'd1:    return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign w_accept   = hsel && htrans[1] && hready;
  assign w_off      = haddr - BASE;
  assign w_in_range = (haddr >= BASE) && (w_off < SPAN);
  assign w_misalign = ((hsize == 3'd1) && haddr[0]) || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign w_err      = !w_in_range || (hsize > 3'd2) || w_misalign;
  assign w_idx      = haddr[AW+1:2];
  assign w_rd_idx   = (r_state == S_WAIT) ? r_idx : w_idx;
  assign w_cur_be   = byteEn(r_size, r_lane);
  // A zero-wait read pipelined behind a write to the same word sees the lanes being written now
  assign w_fwd      = (r_state == S_DATA) && r_write && (r_idx == w_rd_idx);

  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    if (w_fwd) begin
      for (int b = 0; b < 4; b++) begin
        if (w_cur_be[b]) w_rd_word[8*b +: 8] = hwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_DATA && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_cur_be[b]) r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_lane      <= 2'b00;
      r_write     <= 1'b0;
      r_size      <= 3'd0;
      r_wcnt      <= 4'd0;
      r_hrdata    <= 32'h0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_err_cnt   <= 8'h00;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_wcnt == 4'd0) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
            r_hrdata    <= r_write ? 32'h0 : w_rd_word;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
        default: begin
          if (w_accept) begin
            r_idx   <= w_idx;
            r_lane  <= haddr[1:0];
            r_write <= hwrite;
            r_size  <= hsize;
            if (w_err) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
              r_hrdata    <= 32'h0;
            end else if (WAIT_STATES > 0) begin
              r_state     <= S_WAIT;
              r_wcnt      <= WS_INIT;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
              r_hrdata    <= 32'h0;
            end else begin
              r_state     <= S_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
              r_hrdata    <= hwrite ? 32'h0 : w_rd_word;
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= 32'h0;
          end
        end
      endcase
    end
  end

  assign hrdata    = r_hrdata;
  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_comm_ahb_slave.sv
// Scoreboard bench for comm_ahb_slave: one instance with one wait state, one with none,
// driven by a pipelined AHB-Lite master task; a negedge monitor checks every completion.
module tb_comm_ahb_slave;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        active = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] hwdata = 32'h0;

  logic        hsel0, hsel1;
  logic [31:0] hrdata0, hrdata1;
  logic        hreadyout0, hreadyout1;
  logic        hresp0, hresp1;
  logic [7:0]  errCnt0, errCnt1;

  logic        actSel, actReady, actResp;
  logic [31:0] actRdata;

  always #5 clk = ~clk;

  assign hsel0    = hsel && !active;
  assign hsel1    = hsel && active;
  assign actSel   = active ? hsel1 : hsel0;
  assign actReady = active ? hreadyout1 : hreadyout0;
  assign actResp  = active ? hresp1 : hresp0;
  assign actRdata = active ? hrdata1 : hrdata0;

  comm_ahb_slave #(.DEPTH(DEPTH), .WAIT_STATES(1), .BASE(BASE)) dut0 (
    .clk(clk), .rstn(rstn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hreadyout0),
    .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0), .err_cnt(errCnt0)
  );

  comm_ahb_slave #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE(BASE)) dut1 (
    .clk(clk), .rstn(rstn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hreadyout1),
    .hrdata(hrdata1), .hreadyout(hreadyout1), .hresp(hresp1), .err_cnt(errCnt1)
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        resp;
    logic [31:0] rdata;
  } xfer_t;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    logic        chk;
    int          waits;
  } exp_t;

  xfer_t stim[$];
  exp_t  sbq[$];
  int    testsRun = 0;
  int    failCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic finishBench;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCnt);
    $finish;
  endtask

  task automatic addXfer(input logic [31:0] addr, input logic write, input logic [2:0] size,
                         input logic [31:0] wdata, input logic resp, input logic [31:0] rdata);
    xfer_t x;
    x.addr = addr; x.write = write; x.size = size; x.wdata = wdata; x.resp = resp; x.rdata = rdata;
    stim.push_back(x);
  endtask

  task automatic waitReady(input string what);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!actReady && n < 50);
    if (!actReady) begin
      testsRun++;
      failCnt++;
      $display("[TB] FAIL timeout %s: hreadyout still 0 after %0d cycles, expected 1", what, n);
      finishBench();
    end
  endtask

  // Pipelined master: the next address phase overlaps the current data phase
  task automatic applyStimulus;
    int   n = stim.size();
    exp_t e;
    for (int i = 0; i < n; i++) begin
      hsel   = 1'b1;
      haddr  = stim[i].addr;
      htrans = 2'b10;
      hwrite = stim[i].write;
      hsize  = stim[i].size;
      e.resp  = stim[i].resp;
      e.rdata = stim[i].rdata;
      e.chk   = stim[i].resp || !stim[i].write;
      e.waits = stim[i].resp ? 1 : (active ? 0 : 1);
      sbq.push_back(e);
      waitReady("address phase");
      @(posedge clk); #1;
      hwdata = stim[i].write ? stim[i].wdata : 32'h0;
      if (i == n - 1) begin
        hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
      end
    end
    if (n > 0) begin
      waitReady("data phase");
      @(posedge clk); #1;
      hwdata = 32'h0;
    end
    stim.delete();
  endtask

  int   lowCnt = 0;
  bit   inData = 1'b0;
  bit   respLowBad = 1'b0;
  exp_t mon;

  always @(negedge clk) begin
    if (!rstn) begin
      inData = 1'b0; lowCnt = 0; respLowBad = 1'b0;
    end else begin
      if (inData) begin
        if (!actReady) begin
          lowCnt++;
          if (sbq.size() > 0 && actResp !== sbq[0].resp) respLowBad = 1'b1;
        end else begin
          if (sbq.size() == 0) begin
            testsRun++;
            failCnt++;
            $display("[TB] FAIL unexpected completion: got a response, expected none pending");
          end else begin
            mon = sbq.pop_front();
            checkOutput("hresp", 32'(actResp), 32'(mon.resp));
            checkOutput("wait cycles", 32'(lowCnt), 32'(mon.waits));
            checkOutput("hresp while stalled", 32'(respLowBad), 32'h0);
            if (mon.chk) checkOutput("hrdata", actRdata, mon.rdata);
          end
          inData = 1'b0; lowCnt = 0; respLowBad = 1'b0;
        end
      end
      if (actSel && htrans[1] && actReady) inData = 1'b1;
    end
  end

  initial begin
    #200000;
    testsRun++;
    failCnt++;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    finishBench();
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset hreadyout", 32'(hreadyout0), 32'h1);
    checkOutput("reset hresp", 32'(hresp0), 32'h0);
    checkOutput("reset hrdata", hrdata0, 32'h0);
    checkOutput("reset err_cnt", 32'(errCnt0), 32'h0);
    checkOutput("reset hreadyout ws0", 32'(hreadyout1), 32'h1);
    rstn = 1'b1;
    @(posedge clk); #1;

    // One-wait-state slave: write then read back
    active = 1'b0;
    addXfer(BASE + 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0);
    addXfer(BASE + 32'h10, 1'b0, 3'd2, 32'h0,        1'b0, 32'hDEADBEEF);
    applyStimulus();

    // Byte and half-word lanes with replicated write data
    addXfer(BASE + 32'h10, 1'b1, 3'd2, 32'h00000000, 1'b0, 32'h0);
    addXfer(BASE + 32'h13, 1'b1, 3'd0, 32'hA5A5A5A5, 1'b0, 32'h0);
    addXfer(BASE + 32'h10, 1'b0, 3'd2, 32'h0,        1'b0, 32'hA5000000);
    addXfer(BASE + 32'h12, 1'b1, 3'd1, 32'h12341234, 1'b0, 32'h0);
    addXfer(BASE + 32'h10, 1'b0, 3'd2, 32'h0,        1'b0, 32'h12340000);
    applyStimulus();

    // Window edges
    addXfer(BASE + 32'h0,  1'b1, 3'd2, 32'h11223344, 1'b0, 32'h0);
    addXfer(BASE + 32'hFC, 1'b1, 3'd2, 32'hCAFEF00D, 1'b0, 32'h0);
    addXfer(BASE + 32'hFC, 1'b0, 3'd2, 32'h0,        1'b0, 32'hCAFEF00D);
    applyStimulus();
    addXfer(BASE + 32'h100, 1'b0, 3'd2, 32'h0, 1'b1, 32'h0);
    applyStimulus();
    checkOutput("err_cnt after out-of-range", 32'(errCnt0), 32'd1);

    addXfer(BASE + 32'h2, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0);
    addXfer(BASE + 32'h0, 1'b0, 3'd2, 32'h0,        1'b0, 32'h11223344);
    applyStimulus();
    checkOutput("err_cnt after misaligned write", 32'(errCnt0), 32'd2);

    addXfer(BASE + 32'h4,  1'b0, 3'd3, 32'h0,        1'b1, 32'h0);
    addXfer(BASE + 32'h1,  1'b1, 3'd1, 32'h55555555, 1'b1, 32'h0);
    addXfer(32'h1FFF_FFFC, 1'b0, 3'd2, 32'h0,        1'b1, 32'h0);
    addXfer(BASE + 32'h0,  1'b0, 3'd2, 32'h0,        1'b0, 32'h11223344);
    applyStimulus();
    checkOutput("err_cnt after mixed errors", 32'(errCnt0), 32'd5);

    // IDLE and BUSY with hsel must get zero-wait OKAY
    hsel = 1'b1; htrans = 2'b00; haddr = BASE;
    @(negedge clk);
    checkOutput("idle hreadyout", 32'(actReady), 32'h1);
    @(negedge clk);
    checkOutput("idle hresp", 32'(actResp), 32'h0);
    htrans = 2'b01;
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy hreadyout", 32'(actReady), 32'h1);
    hsel = 1'b0; htrans = 2'b00; haddr = 32'h0;
    @(posedge clk); #1;

    for (int i = 0; i < 260; i++) addXfer(BASE + 32'h100, 1'b0, 3'd2, 32'h0, 1'b1, 32'h0);
    applyStimulus();
    checkOutput("err_cnt saturated", 32'(errCnt0), 32'h000000FF);

    // Zero-wait-state slave: pipelined read-after-write
    active = 1'b1;
    addXfer(BASE + 32'h0, 1'b1, 3'd2, 32'h00000001, 1'b0, 32'h0);
    addXfer(BASE + 32'h0, 1'b0, 3'd2, 32'h0,        1'b0, 32'h00000001);
    addXfer(BASE + 32'h8, 1'b1, 3'd2, 32'h00000000, 1'b0, 32'h0);
    addXfer(BASE + 32'h9, 1'b1, 3'd0, 32'h77777777, 1'b0, 32'h0);
    addXfer(BASE + 32'h8, 1'b0, 3'd2, 32'h0,        1'b0, 32'h00007700);
    addXfer(BASE + 32'h6, 1'b0, 3'd2, 32'h0,        1'b1, 32'h0);
    applyStimulus();
    checkOutput("ws0 err_cnt", 32'(errCnt1), 32'd1);
    active = 1'b0;

    // Reset during the wait state of a write must drop it
    addXfer(BASE + 32'h20, 1'b1, 3'd2, 32'h00000005, 1'b0, 32'h0);
    applyStimulus();
    hsel = 1'b1; haddr = BASE + 32'h20; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    waitReady("aborted write accept");
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd0;
    hwdata = 32'hFFFF0000;
    checkOutput("wait before abort", 32'(hreadyout0), 32'h0);
    #2 rstn = 1'b0;
    #1;
    checkOutput("abort hreadyout", 32'(hreadyout0), 32'h1);
    checkOutput("abort hresp", 32'(hresp0), 32'h0);
    checkOutput("abort hrdata", hrdata0, 32'h0);
    checkOutput("abort err_cnt", 32'(errCnt0), 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    hwdata = 32'h0;
    @(posedge clk); #1;
    addXfer(BASE + 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 32'h00000005);
    applyStimulus();

    repeat (2) @(posedge clk);
    checkOutput("scoreboard drained", 32'(sbq.size()), 32'h0);
    finishBench();
  end

endmodule
